// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and Gray/binary pointer conversions
package fifo_pkg;

    localparam int PTR_WIDTH  = 3;
    localparam int DATA_WIDTH = 8;
    localparam int AE_LEVEL   = 2;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
        return b;
    endfunction

endpackage

// File: rtl/fifo_read_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing a Gray pointer into the read domain
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             rclock,
    input  logic             rreset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] wq1;

    // First flop may go metastable; second flop gives it a cycle to resolve
    always_ff @(posedge rclock or negedge rreset) begin
        if (!rreset) begin
            wq1 <= '0;
            q   <= '0;
        end else begin
            wq1 <= d;
            q   <= wq1;
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side FIFO control with pointer sync, RAM fetch and 2-entry output skid buffer
module fifo_read_ctrl #(
    parameter int PTR_WIDTH  = fifo_pkg::PTR_WIDTH,
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int AE_LEVEL   = fifo_pkg::AE_LEVEL
) (
    input  logic                  rclock,
    input  logic                  rreset,
    input  logic [PTR_WIDTH:0]    gray_wptr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  ram_ren,
    output logic [PTR_WIDTH-1:0]  raddr,
    output logic [PTR_WIDTH:0]    gray_rptr,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    rlevel
);

    import fifo_pkg::*;

    localparam int PW = PTR_WIDTH + 1;

    logic [PW-1:0]         wq2;
    logic [PW-1:0]         wbin;
    logic [PW-1:0]         rbin;
    logic [PW-1:0]         rbin_next;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] skid;
    logic                  head_v;
    logic                  skid_v;
    logic                  inflight;
    logic                  pop;
    logic [1:0]            credits;

    sync_2ff #(.WIDTH(PW)) u_sync (
        .rclock (rclock),
        .rreset (rreset),
        .d      (gray_wptr),
        .q      (wq2)
    );

    // Fetch decision: a read is issued only when a buffer slot is guaranteed for its data
    always_comb begin
        wbin      = PW'(gray2bin(32'(wq2)));
        pop       = head_v & m_ready;
        credits   = 2'(head_v) + 2'(skid_v) + 2'(inflight);
        empty     = wq2 == gray_rptr;
        ram_ren   = !empty && (credits - 2'(pop)) < 2'd2;
        rbin_next = rbin + PW'(ram_ren);
    end

    assign raddr        = rbin[PTR_WIDTH-1:0];
    assign almost_empty = int'(rlevel) <= AE_LEVEL;
    assign m_valid      = head_v;
    assign m_data       = head;

    // Read pointer, its Gray copy for the write domain, fill level and RAM-latency tracker
    always_ff @(posedge rclock or negedge rreset) begin
        if (!rreset) begin
            rbin      <= '0;
            gray_rptr <= '0;
            rlevel    <= '0;
            inflight  <= 1'b0;
        end else begin
            rbin      <= rbin_next;
            gray_rptr <= PW'(bin2gray(32'(rbin_next)));
            rlevel    <= wbin - rbin;
            inflight  <= ram_ren;
        end
    end

    // Output buffer: returning data fills the head first, the skid only when the head is held
    always_ff @(posedge rclock or negedge rreset) begin
        if (!rreset) begin
            head   <= '0;
            skid   <= '0;
            head_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (pop && skid_v) begin
            head   <= skid;
            skid_v <= 1'b0;
        end else if (inflight && (!head_v || pop)) begin
            head   <= ram_rdata;
            head_v <= 1'b1;
        end else if (inflight) begin
            skid   <= ram_rdata;
            skid_v <= 1'b1;
        end else if (pop) begin
            head_v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: randomized scoreboard bench with a write-side and RAM model
module tb_fifo_read_ctrl;

    logic       rclock = 1'b0;
    logic       rreset = 1'b0;
    logic [3:0] gray_wptr = '0;
    logic [7:0] ram_rdata = '0;
    logic       ram_ren;
    logic [2:0] raddr;
    logic [3:0] gray_rptr;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rlevel;

    fifo_read_ctrl dut (
        .rclock       (rclock),
        .rreset       (rreset),
        .gray_wptr    (gray_wptr),
        .ram_rdata    (ram_rdata),
        .ram_ren      (ram_ren),
        .raddr        (raddr),
        .gray_rptr    (gray_rptr),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rlevel       (rlevel)
    );

    always #5 rclock = ~rclock;

    logic [7:0] mem [8];
    logic [7:0] exp_q [$];
    logic [3:0] wcount = '0;
    int wtotal = 0;
    int popped = 0;
    int ren_total = 0;
    int checks = 0;
    int errors = 0;
    logic       hold = 1'b0;
    logic [7:0] hold_data = '0;

    // Synchronous-read RAM model
    always @(posedge rclock) if (ram_ren) ram_rdata <= mem[raddr];

    // Monitor: pops the scoreboard on every accepted word and watches for underflow and instability
    always @(negedge rclock) begin
        if (!rreset) begin
            hold = 1'b0;
        end else begin
            if (ram_ren) begin
                checks++;
                if (ren_total >= wtotal) begin
                    errors++;
                    $display("FAIL underflow: fetch %0d issued with only %0d words written", ren_total + 1, wtotal);
                end
                ren_total++;
            end
            if (hold) begin
                checks++;
                if (!m_valid || m_data !== hold_data) begin
                    errors++;
                    $display("FAIL stall_stable: m_valid=%0b m_data=%0h, required 1 and %0h", m_valid, m_data, hold_data);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %0h with no word expected", m_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++;
                        $display("FAIL data_order: got %0h expected %0h", m_data, e);
                    end
                end
                popped++;
            end
            hold = m_valid && !m_ready;
            hold_data = m_data;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge rclock);
        #1;
    endtask

    task automatic write_word();
        logic [7:0] d;
        d = 8'($urandom);
        mem[wcount[2:0]] = d;
        wcount = wcount + 4'd1;
        wtotal++;
        gray_wptr = wcount ^ (wcount >> 1);
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        rreset = 1'b0;
        gray_wptr = '0;
        wcount = '0;
        wtotal = 0;
        popped = 0;
        ren_total = 0;
        exp_q.delete();
        tick(3);
        chk("rst_empty", int'(empty), 1);
        chk("rst_almost_empty", int'(almost_empty), 1);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_gray_rptr", int'(gray_rptr), 0);
        chk("rst_rlevel", int'(rlevel), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_ram_ren", int'(ram_ren), 0);
        rreset = 1'b1;
        tick(2);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300 && exp_q.size() > 0; k++) tick();
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ren0;
        int lat;
        int v;
        do_reset();

        // Single word: latency, one fetch, pointer update
        m_ready = 1'b1;
        ren0 = ren_total;
        write_word();
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (m_valid) begin
                lat = k;
                break;
            end
        end
        chk("single_latency", lat, 4);
        tick(2);
        chk("single_ren_count", ren_total - ren0, 1);
        chk("single_gray_rptr", int'(gray_rptr), 1);
        chk("single_empty", int'(empty), 1);

        // Back-pressure: only two fetches fit the buffer
        m_ready = 1'b0;
        ren0 = ren_total;
        repeat (5) begin
            write_word();
            tick();
        end
        tick(8);
        chk("bp_ren_count", ren_total - ren0, 2);
        chk("bp_rlevel", int'(rlevel), 3);
        chk("bp_m_valid", int'(m_valid), 1);
        chk("bp_head", int'(m_data), int'(exp_q[0]));
        m_ready = 1'b1;
        v = 0;
        for (int k = 0; k < 5; k++) begin
            v += int'(m_valid);
            tick();
        end
        chk("bp_valid_run", v, 5);
        wait_drain();

        // Almost-empty threshold crossing
        m_ready = 1'b0;
        repeat (6) begin
            write_word();
            tick();
        end
        tick(8);
        chk("ae_rlevel4", int'(rlevel), 4);
        chk("ae_low_at4", int'(almost_empty), 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("ae_rlevel_hold4", int'(rlevel), 4);
        tick();
        chk("ae_rlevel3", int'(rlevel), 3);
        chk("ae_low_at3", int'(almost_empty), 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("ae_rlevel_hold3", int'(rlevel), 3);
        chk("ae_still_low", int'(almost_empty), 0);
        tick();
        chk("ae_rlevel2", int'(rlevel), 2);
        chk("ae_high_at2", int'(almost_empty), 1);
        m_ready = 1'b1;
        wait_drain();

        // Pointer wrap: 20 words from a fresh reset
        do_reset();
        m_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 50 && wtotal - popped >= 8; k++) tick();
            write_word();
            tick();
        end
        wait_drain();
        tick(3);
        chk("wrap_popped", popped, 20);
        chk("wrap_gray_rptr", int'(gray_rptr), 6);
        chk("wrap_empty", int'(empty), 1);
        chk("wrap_rlevel", int'(rlevel), 0);

        // Mid-stream reset with the skid full
        m_ready = 1'b0;
        repeat (6) begin
            write_word();
            tick();
        end
        tick(8);
        chk("mid_valid_before", int'(m_valid), 1);
        #2;
        rreset = 1'b0;
        #1;
        chk("mid_valid_in_reset", int'(m_valid), 0);
        chk("mid_ren_in_reset", int'(ram_ren), 0);
        chk("mid_data_in_reset", int'(m_data), 0);
        do_reset();
        m_ready = 1'b1;
        tick(10);
        chk("mid_no_stale_valid", int'(m_valid), 0);
        chk("mid_no_stale_pops", popped, 0);

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 600; c++) begin
            m_ready = $urandom_range(0, 3) != 0;
            if (wtotal - popped < 8 && $urandom_range(0, 1) == 1) write_word();
            tick();
        end
        m_ready = 1'b1;
        wait_drain();
        tick(4);
        chk("rand_all_popped", popped, wtotal);
        chk("rand_empty", int'(empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
